serial_pattern_detector: RTL and testbench

- Consumes the one-bit-per-clock serial stream (`inp`, `clk`) produced by the random stimulus generator.
- Detects a parameterised bit pattern, overlaps allowed, and emits a one-cycle registered match pulse.
- Keeps a saturating count of matches and reports whether it has received enough bits since reset to match.
- Sits directly downstream of the stimulus source; its outputs feed the checker/monitor.

---
 rtl/serial_pattern_detector.sv | 103 ++++++++++
 tb/tb_serial_pattern_detector.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_detector.sv
// Serial bit-pattern detector: shifts in one bit per clock, flags each
// (possibly overlapping) occurrence of PATTERN with a one-cycle registered
// pulse, keeps a saturating match count and reports when the history is full.
module serial_pattern_detector #(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inp,
    input  logic             clr,
    output logic             out,
    output logic [CNT_W-1:0] count,
    output logic             ready
);

    localparam int unsigned HIST_W = PAT_LEN - 1;
    localparam int unsigned FILL_W = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_PREV = FILL_W'(PAT_LEN - 2);

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [HIST_W-1:0]   hist;
    logic [HIST_W-1:0]   hist_next;
    logic [FILL_W-1:0]   fill;
    logic [FILL_W-1:0]   fill_next;
    logic [PAT_LEN-1:0]  cand;
    logic                hit;
    logic                out_next;
    logic [CNT_W-1:0]    count_next;

    // A two-bit pattern keeps only one history bit, so there is nothing to slice.
    generate
        if (HIST_W == 1) begin : g_hist_one
            assign hist_next = inp;
        end else begin : g_hist_many
            assign hist_next = {hist[HIST_W-2:0], inp};
        end
    endgenerate

    // Candidate word: oldest history bit first, the bit being sampled last.
    assign cand  = {hist, inp};
    assign hit   = (cand == PATTERN);
    assign ready = (state == RUN);

    // Next-state logic: count the fill, then compare every cycle in RUN.
    always_comb begin
        state_next = state;
        fill_next  = fill;
        out_next   = 1'b0;
        case (state)
            FILL: begin
                fill_next = fill + 1'b1;
                if (fill == FILL_PREV) begin
                    fill_next  = FILL_LAST;
                    state_next = RUN;
                end
            end
            RUN: begin
                out_next = hit;
            end
            default: begin
                state_next = FILL;
                fill_next  = '0;
            end
        endcase
    end

    // Match counter: clear wins over a same-edge match, otherwise saturate.
    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (out_next && (count != '1)) begin
            count_next = count + 1'b1;
        end
    end

    // State, history and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist  <= '0;
            fill  <= '0;
            state <= FILL;
            out   <= 1'b0;
            count <= '0;
        end else begin
            hist  <= hist_next;
            fill  <= fill_next;
            state <= state_next;
            out   <= out_next;
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector: three instances (1011/8-bit count,
// 1011/2-bit count, 1111/8-bit count) share one stimulus stream and are
// compared against a queue-based model of the last received bits.
module tb_serial_pattern_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       inp;
    logic       clr;
    logic       out_a, out_b, out_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;

    serial_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .inp(inp), .clr(clr),
        .out(out_a), .count(cnt_a), .ready(rdy_a)
    );
    serial_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .inp(inp), .clr(clr),
        .out(out_b), .count(cnt_b), .ready(rdy_b)
    );
    serial_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1111), .CNT_W(8)) dut_c (
        .clk(clk), .reset(reset), .inp(inp), .clr(clr),
        .out(out_c), .count(cnt_c), .ready(rdy_c)
    );

    always #5 clk = ~clk;

    logic       o_act[3];
    logic       r_act[3];
    logic [7:0] c_act[3];
    assign o_act[0] = out_a;
    assign o_act[1] = out_b;
    assign o_act[2] = out_c;
    assign r_act[0] = rdy_a;
    assign r_act[1] = rdy_b;
    assign r_act[2] = rdy_c;
    assign c_act[0] = cnt_a;
    assign c_act[1] = {6'b0, cnt_b};
    assign c_act[2] = cnt_c;

    int total  = 0;
    int passed = 0;

    // Reference model: the bits received since reset (last four kept).
    bit         mq[$];
    int         mcnt[3];
    bit         mout[3];
    logic [3:0] pats[3];
    int         maxc[3];

    typedef struct {
        bit inp;
        bit clr;
        bit e_out;
        int e_count;
        bit e_ready;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic bit model_hit(input int d);
        if (mq.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++)
            if (mq[i] != pats[d][3-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input bit b, input bit c);
        mq.push_back(b);
        if (mq.size() > 4) void'(mq.pop_front());
        for (int d = 0; d < 3; d++) begin
            mout[d] = model_hit(d);
            if (c) mcnt[d] = 0;
            else if (mout[d] && mcnt[d] < maxc[d]) mcnt[d]++;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int d = 0; d < 3; d++) begin
            mcnt[d] = 0;
            mout[d] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s out[%0d]", tag, d), int'(o_act[d]), int'(mout[d]));
            check($sformatf("%s count[%0d]", tag, d), int'(c_act[d]), mcnt[d]);
            check($sformatf("%s ready[%0d]", tag, d), int'(r_act[d]), int'(mq.size() >= 3));
        end
    endtask

    task automatic step(input bit b, input bit c, input string tag);
        inp = b;
        clr = c;
        @(posedge clk);
        model_edge(b, c);
        #1;
        check_all(tag);
    endtask

    // Reset pulse placed between clock edges; outputs must clear with no edge.
    task automatic mid_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int pulses_b;
        bit ec[6];
        bit rb, rc;

        pats[0] = 4'b1011; maxc[0] = 255;
        pats[1] = 4'b1011; maxc[1] = 3;
        pats[2] = 4'b1111; maxc[2] = 255;

        // Stream 1011011 then 0,1,1(clr),0,1,1 against the 1011/8-bit instance.
        tbl[0]  = '{1, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 1};
        tbl[3]  = '{1, 0, 1, 1, 1};
        tbl[4]  = '{0, 0, 0, 1, 1};
        tbl[5]  = '{1, 0, 0, 1, 1};
        tbl[6]  = '{1, 0, 1, 2, 1};
        tbl[7]  = '{0, 0, 0, 2, 1};
        tbl[8]  = '{1, 0, 0, 2, 1};
        tbl[9]  = '{1, 1, 1, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 1};
        tbl[11] = '{1, 0, 0, 0, 1};
        tbl[12] = '{1, 0, 1, 1, 1};

        reset = 1'b1;
        inp   = 1'b0;
        clr   = 1'b0;
        model_reset();
        #12;
        check_all("reset_state");
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].inp, tbl[i].clr, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d out_a", i), int'(out_a), int'(tbl[i].e_out));
            check($sformatf("tbl%0d count_a", i), int'(cnt_a), tbl[i].e_count);
            check($sformatf("tbl%0d ready_a", i), int'(rdy_a), int'(tbl[i].e_ready));
        end

        // Partial pattern, reset mid-cycle, then the final bit must not match.
        mid_reset();
        step(1, 0, "pre_rst");
        step(0, 0, "pre_rst");
        step(1, 0, "pre_rst");
        mid_reset();
        step(1, 0, "post_rst");
        check("post_rst out_a", int'(out_a), 0);
        check("post_rst count_a", int'(cnt_a), 0);
        check("post_rst ready_a", int'(rdy_a), 0);

        // 1011 five times: narrow counter saturates at 3.
        mid_reset();
        pulses_b = 0;
        for (int r = 0; r < 5; r++) begin
            step(1, 0, "sat"); pulses_b += int'(out_b);
            step(0, 0, "sat"); pulses_b += int'(out_b);
            step(1, 0, "sat"); pulses_b += int'(out_b);
            step(1, 0, "sat"); pulses_b += int'(out_b);
        end
        check("sat pulses_b", pulses_b, 5);
        check("sat count_b", int'(cnt_b), 3);
        check("sat count_a", int'(cnt_a), 5);

        // Six 1s into the 1111 instance: back-to-back pulses on edges 4..6.
        mid_reset();
        ec = '{0, 0, 0, 1, 1, 1};
        for (int i = 0; i < 6; i++) begin
            step(1, 0, "ones");
            check($sformatf("ones%0d out_c", i), int'(out_c), int'(ec[i]));
        end
        check("ones count_c", int'(cnt_c), 3);

        // Random stream with occasional clears and mid-cycle resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) mid_reset();
            rb = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 19) == 0);
            step(rb, rc, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
